// File: rtl/i2si_deserializer.sv
// I2S receive deserializer: synchronises the external bit clock, word select
// and data into clk, aligns on the first word-select change, and delivers
// left/right words left-justified with a one-clk transfer pulse each.
// Optional length check: define I2SI_DES_LENERR_EN to build the len_err port.
module i2si_deserializer #(
  parameter int BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        i2s_sck,
  input  logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [31:0] l_data,
  output logic        l_xfc,
  output logic [31:0] r_data,
  output logic        r_xfc
`ifdef I2SI_DES_LENERR_EN
  ,
  output logic        len_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  if (BITS < 8 || BITS > 32) begin : g_bits_range
    $error("i2si_deserializer: BITS must be in 8..32");
  end

  state_t      state, state_nxt;
  logic [1:0]  sck_sync, ws_sync, sd_sync;
  logic        sck_d;
  logic        sck_rise, ws_s, sd_s;
  logic [5:0]  cnt, cnt_nxt, done_cnt;
  logic [31:0] shreg, shreg_nxt, word;
  logic        ws_prev, ws_prev_nxt;
  logic [31:0] l_data_nxt, r_data_nxt;
  logic        l_xfc_nxt, r_xfc_nxt;
`ifdef I2SI_DES_LENERR_EN
  logic        len_err_nxt;
`endif

  // Two-flop synchronizers for the asynchronous pins plus sck edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], i2s_sck};
      ws_sync  <= {ws_sync[0], i2s_ws};
      sd_sync  <= {sd_sync[0], i2s_sd};
      sck_d    <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign ws_s     = ws_sync[1];
  assign sd_s     = sd_sync[1];

  // Current word with the sampled bit inserted; bits past 32 are dropped
  always_comb begin
    word = shreg;
    if (cnt < 6'd32) word[5'd31 - cnt[4:0]] = sd_s;
    done_cnt = (cnt == 6'd33) ? 6'd33 : cnt + 6'd1;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    ws_prev_nxt = ws_prev;
    l_data_nxt  = l_data;
    r_data_nxt  = r_data;
    l_xfc_nxt   = 1'b0;
    r_xfc_nxt   = 1'b0;
`ifdef I2SI_DES_LENERR_EN
    len_err_nxt = 1'b0;
`endif
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt   = ALIGN;
          ws_prev_nxt = ws_s;
        end
        ALIGN: begin
          if (sck_rise && (ws_s != ws_prev)) begin
            state_nxt   = RUN;
            cnt_nxt     = '0;
            shreg_nxt   = '0;
            ws_prev_nxt = ws_s;
          end
        end
        RUN: begin
          if (sck_rise) begin
            if (ws_s == ws_prev) begin
              shreg_nxt = word;
              cnt_nxt   = done_cnt;
            end else begin
              // The bit sampled with the new ws is still the old word's LSB
              if (ws_prev) begin
                r_data_nxt = word;
                r_xfc_nxt  = 1'b1;
              end else begin
                l_data_nxt = word;
                l_xfc_nxt  = 1'b1;
              end
`ifdef I2SI_DES_LENERR_EN
              len_err_nxt = (done_cnt != 6'(BITS));
`endif
              cnt_nxt     = '0;
              shreg_nxt   = '0;
              ws_prev_nxt = ws_s;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      ws_prev <= 1'b0;
      l_data  <= '0;
      r_data  <= '0;
      l_xfc   <= 1'b0;
      r_xfc   <= 1'b0;
`ifdef I2SI_DES_LENERR_EN
      len_err <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      ws_prev <= ws_prev_nxt;
      l_data  <= l_data_nxt;
      r_data  <= r_data_nxt;
      l_xfc   <= l_xfc_nxt;
      r_xfc   <= r_xfc_nxt;
`ifdef I2SI_DES_LENERR_EN
      len_err <= len_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_i2si_deserializer.sv
// Directed bench for i2si_deserializer: clk 10 ns, I2S bit clock 160 ns (16x).
module tb_i2si_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sck = 1'b0;
  logic        ws = 1'b0;
  logic        sd = 1'b0;
  logic [31:0] l_data, r_data;
  logic        l_xfc, r_xfc;
`ifdef I2SI_DES_LENERR_EN
  logic        len_err;
`endif

  int checks = 0;
  int errors = 0;

  int          l_count = 0, r_count = 0;
  logic [31:0] l_last = '0, r_last = '0;
  logic        l_le = 1'b0, r_le = 1'b0;
  int          l_wide = 0, r_wide = 0, both_hi = 0, hold_err = 0;
  logic        l_xfc_d = 1'b0, r_xfc_d = 1'b0, rst_d = 1'b1;
  logic [31:0] l_prev = '0, r_prev = '0;

  always #5 clk = ~clk;

  i2si_deserializer #(.BITS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i2s_sck (sck),
    .i2s_ws  (ws),
    .i2s_sd  (sd),
    .l_data  (l_data),
    .l_xfc   (l_xfc),
    .r_data  (r_data),
    .r_xfc   (r_xfc)
`ifdef I2SI_DES_LENERR_EN
    ,
    .len_err (len_err)
`endif
  );

  // Record transfer pulses and watch pulse width, exclusivity and data hold
  always @(negedge clk) begin
    if (l_xfc === 1'b1) begin
      l_count++;
      l_last = l_data;
`ifdef I2SI_DES_LENERR_EN
      l_le = len_err;
`endif
    end
    if (r_xfc === 1'b1) begin
      r_count++;
      r_last = r_data;
`ifdef I2SI_DES_LENERR_EN
      r_le = len_err;
`endif
    end
    if (l_xfc === 1'b1 && l_xfc_d === 1'b1) l_wide++;
    if (r_xfc === 1'b1 && r_xfc_d === 1'b1) r_wide++;
    if (l_xfc === 1'b1 && r_xfc === 1'b1) both_hi++;
    if (!rst && !rst_d) begin
      if (l_xfc !== 1'b1 && l_data !== l_prev) hold_err++;
      if (r_xfc !== 1'b1 && r_data !== r_prev) hold_err++;
    end
    l_prev  = l_data;
    r_prev  = r_data;
    l_xfc_d = l_xfc;
    r_xfc_d = r_xfc;
    rst_d   = rst;
  end

  task automatic send_bit(input logic w, input logic d);
    sck = 1'b0;
    ws  = w;
    sd  = d;
    #80;
    sck = 1'b1;
    #80;
  endtask

  // I2S framing: ws flips together with the LSB of the outgoing word
  task automatic send_word(input logic ch, input logic [39:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? ~ch : ch, data[i]);
  endtask

  task automatic sck_low();
    sck = 1'b0;
    #80;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sck = ~sck;
      ws  = 1'($urandom);
      sd  = ~sd;
    end
    @(negedge clk);
    checks++;
    if (l_data !== 32'h0) begin errors++; $display("FAIL reset_l_data: got %h expected %h", l_data, 32'h0); end
    checks++;
    if (r_data !== 32'h0) begin errors++; $display("FAIL reset_r_data: got %h expected %h", r_data, 32'h0); end
    checks++;
    if (l_xfc !== 1'b0 || r_xfc !== 1'b0) begin errors++; $display("FAIL reset_xfc: got %b%b expected 00", l_xfc, r_xfc); end
    checks++;
    if (l_count != 0 || r_count != 0) begin errors++; $display("FAIL reset_pulses: got %0d/%0d expected 0/0", l_count, r_count); end
`ifdef I2SI_DES_LENERR_EN
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
`endif
    sck = 1'b0;
    ws  = 1'b1;
    sd  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_bit(1'b0, 1'b0);
    send_word(1'b0, 40'h80000001, 32);
    checks++;
    if (l_count != 1 || l_last !== 32'h80000001) begin errors++; $display("FAIL basic_left: got %0d/%h expected 1/%h", l_count, l_last, 32'h80000001); end
    checks++;
    if (r_count != 0) begin errors++; $display("FAIL basic_no_right: got %0d expected 0", r_count); end
    send_word(1'b1, 40'hDEADBEEF, 32);
    checks++;
    if (r_count != 1 || r_last !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_right: got %0d/%h expected 1/%h", r_count, r_last, 32'hDEADBEEF); end
`ifdef I2SI_DES_LENERR_EN
    checks++;
    if (l_le !== 1'b0 || r_le !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %b%b expected 00", l_le, r_le); end
`endif
  endtask

  task automatic test_short_word();
    send_word(1'b0, 40'hABCDEF, 24);
    checks++;
    if (l_count != 2 || l_last !== 32'hABCDEF00) begin errors++; $display("FAIL short_left: got %0d/%h expected 2/%h", l_count, l_last, 32'hABCDEF00); end
`ifdef I2SI_DES_LENERR_EN
    checks++;
    if (l_le !== 1'b1) begin errors++; $display("FAIL short_len_err: got %b expected 1", l_le); end
`endif
    send_word(1'b1, 40'h123456, 24);
    checks++;
    if (r_count != 2 || r_last !== 32'h12345600) begin errors++; $display("FAIL short_right: got %0d/%h expected 2/%h", r_count, r_last, 32'h12345600); end
  endtask

  task automatic test_en_drop();
    logic [31:0] partial;
    partial = 32'h5555AAAA;
    send_word(1'b0, 40'h11112222, 32);
    checks++;
    if (l_count != 3 || l_last !== 32'h11112222) begin errors++; $display("FAIL endrop_left: got %0d/%h expected 3/%h", l_count, l_last, 32'h11112222); end
    for (int i = 31; i >= 16; i--) send_bit(1'b1, partial[i]);
    sck_low();
    @(posedge clk);
    #1 en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (l_data !== 32'h11112222 || r_data !== 32'h12345600) begin errors++; $display("FAIL endrop_hold: got %h/%h expected %h/%h", l_data, r_data, 32'h11112222, 32'h12345600); end
    @(posedge clk);
    #1 en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 15; i >= 0; i--) send_bit((i == 0) ? 1'b0 : 1'b1, partial[i]);
    checks++;
    if (r_count != 2) begin errors++; $display("FAIL endrop_discard: got %0d r pulses expected 2", r_count); end
    send_word(1'b0, 40'hCAFEF00D, 32);
    send_word(1'b1, 40'h0BADC0DE, 32);
    checks++;
    if (l_count != 4 || l_last !== 32'hCAFEF00D) begin errors++; $display("FAIL endrop_next_left: got %0d/%h expected 4/%h", l_count, l_last, 32'hCAFEF00D); end
    checks++;
    if (r_count != 3 || r_last !== 32'h0BADC0DE) begin errors++; $display("FAIL endrop_next_right: got %0d/%h expected 3/%h", r_count, r_last, 32'h0BADC0DE); end
  endtask

  task automatic test_long_word();
    send_word(1'b0, 40'h12345678AB, 40);
    checks++;
    if (l_count != 5 || l_last !== 32'h12345678) begin errors++; $display("FAIL long_left: got %0d/%h expected 5/%h", l_count, l_last, 32'h12345678); end
    send_word(1'b1, 40'hFEDCBA9876, 40);
    checks++;
    if (r_count != 4 || r_last !== 32'hFEDCBA98) begin errors++; $display("FAIL long_right: got %0d/%h expected 4/%h", r_count, r_last, 32'hFEDCBA98); end
`ifdef I2SI_DES_LENERR_EN
    checks++;
    if (l_le !== 1'b1 || r_le !== 1'b1) begin errors++; $display("FAIL long_len_err: got %b%b expected 11", l_le, r_le); end
`endif
  endtask

  task automatic test_rst_mid_word();
    logic [31:0] aborted;
    aborted = 32'h0F0F0F0F;
    for (int i = 31; i >= 22; i--) send_bit(1'b0, aborted[i]);
    sck_low();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (l_data !== 32'h0 || r_data !== 32'h0) begin errors++; $display("FAIL rstmid_zero: got %h/%h expected 0/0", l_data, r_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 21; i >= 0; i--) send_bit((i == 0) ? 1'b1 : 1'b0, aborted[i]);
    checks++;
    if (l_count != 5 || l_data !== 32'h0) begin errors++; $display("FAIL rstmid_dropped: got %0d/%h expected 5/%h", l_count, l_data, 32'h0); end
    send_word(1'b1, 40'h7, 32);
    checks++;
    if (r_count != 5 || r_last !== 32'h7) begin errors++; $display("FAIL rstmid_first_right: got %0d/%h expected 5/%h", r_count, r_last, 32'h7); end
    send_word(1'b0, 40'd25, 32);
    send_word(1'b1, 40'd50, 32);
    checks++;
    if (l_count != 6 || l_last !== 32'd25) begin errors++; $display("FAIL rstmid_left: got %0d/%h expected 6/%h", l_count, l_last, 32'd25); end
    checks++;
    if (r_count != 6 || r_last !== 32'd50) begin errors++; $display("FAIL rstmid_right: got %0d/%h expected 6/%h", r_count, r_last, 32'd50); end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (l_wide != 0 || r_wide != 0) begin errors++; $display("FAIL pulse_width: got %0d/%0d wide pulses expected 0/0", l_wide, r_wide); end
    checks++;
    if (both_hi != 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", both_hi); end
    checks++;
    if (hold_err != 0) begin errors++; $display("FAIL data_hold: got %0d changes without xfc expected 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_word();
    test_en_drop();
    test_long_word();
    test_rst_mid_word();
    test_pulse_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
